add_round_key_pipe: RTL and testbench

Parametrised, pipelined AddRoundKey stage for the AES datapath. It holds a local round-key store of NKEYS entries, each NWORDS 32-bit words, written by the key-expansion block. For each state it XORs in the round key selected by the round index, under a valid/ready handshake. Its result feeds SubBytes / the next round register. It flags requests for unloaded or out-of-range keys and counts them.

---
 rtl/aes_pkg.sv | 19 +
 rtl/round_key_store.sv | 60 ++++++
 rtl/add_round_key_pipe.sv | 86 ++++++++
 tb/tb_add_round_key_pipe.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES datapath constants and word helpers
package aes_pkg;

  localparam int WORD_W        = 32;
  localparam int AES128_NWORDS = 4;
  localparam int AES128_NKEYS  = 11;
  // Widest state the word helper handles; callers zero-extend narrower vectors.
  localparam int MAX_NWORDS    = 8;

  // Word i of an n-word vector, word 0 being the most significant.
  function automatic logic [WORD_W-1:0] word_sel(
    input logic [WORD_W*MAX_NWORDS-1:0] v,
    input int                           n,
    input int                           i
  );
    return v[WORD_W*(n-1-i) +: WORD_W];
  endfunction

endpackage

// File: rtl/round_key_store.sv
// rtl/round_key_store.sv - round-key register file with per-slot loaded bits
module round_key_store
  import aes_pkg::*;
#(
  parameter int NWORDS = AES128_NWORDS,
  parameter int NKEYS  = AES128_NKEYS,
  parameter int RW     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [RW-1:0]            wr_idx,
  input  logic [WORD_W*NWORDS-1:0] wr_data,
  input  logic                     clr,
  input  logic [RW-1:0]            rd_idx,
  output logic [WORD_W*NWORDS-1:0] rd_key,
  output logic                     rd_hit
);

  localparam int            DW = WORD_W * NWORDS;
  localparam logic [RW:0]   NK = (RW+1)'(NKEYS);

  logic [DW-1:0]    keys [NKEYS];
  logic [NKEYS-1:0] loaded;
  logic             wr_ok;
  logic             rd_in;

  assign wr_ok = wr_en && ({1'b0, wr_idx} < NK);
  assign rd_in = {1'b0, rd_idx} < NK;

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      keys[wr_idx] <= wr_data;
    end
  end

  // Clear is scheduled before the write so a same-cycle write survives it.
  always_ff @(posedge clk) begin
    if (rst) begin
      loaded <= '0;
    end else begin
      if (clr) begin
        loaded <= '0;
      end
      if (wr_ok) begin
        loaded[wr_idx] <= 1'b1;
      end
    end
  end

  always_comb begin
    rd_key = '0;
    rd_hit = 1'b0;
    if (rd_in) begin
      rd_key = keys[rd_idx];
      rd_hit = loaded[rd_idx];
    end
  end

endmodule

// File: rtl/add_round_key_pipe.sv
// rtl/add_round_key_pipe.sv - pipelined AddRoundKey stage with local key store
module add_round_key_pipe
  import aes_pkg::*;
#(
  parameter int NWORDS = AES128_NWORDS,
  parameter int NKEYS  = AES128_NKEYS,
  parameter int RW     = 4,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     key_wr_en,
  input  logic [RW-1:0]            key_wr_idx,
  input  logic [WORD_W*NWORDS-1:0] key_wr_data,
  input  logic                     key_clr,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [WORD_W*NWORDS-1:0] s_data,
  input  logic [RW-1:0]            s_round,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [WORD_W*NWORDS-1:0] m_data,
  output logic                     m_err,
  output logic [CNT_W-1:0]         err_cnt
);

  localparam int DW = WORD_W * NWORDS;

  logic [DW-1:0]                rd_key;
  logic                         rd_hit;
  logic [WORD_W*MAX_NWORDS-1:0] s_ext;
  logic [WORD_W*MAX_NWORDS-1:0] k_ext;
  logic [DW-1:0]                xored;
  logic                         accept;

  round_key_store #(
    .NWORDS (NWORDS),
    .NKEYS  (NKEYS),
    .RW     (RW)
  ) u_store (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (key_wr_en),
    .wr_idx  (key_wr_idx),
    .wr_data (key_wr_data),
    .clr     (key_clr),
    .rd_idx  (s_round),
    .rd_key  (rd_key),
    .rd_hit  (rd_hit)
  );

  always_comb begin
    s_ext          = '0;
    k_ext          = '0;
    s_ext[DW-1:0]  = s_data;
    k_ext[DW-1:0]  = rd_key;
  end

  for (genvar i = 0; i < NWORDS; i++) begin : g_word
    assign xored[DW-1-WORD_W*i -: WORD_W] =
      word_sel(s_ext, NWORDS, i) ^ word_sel(k_ext, NWORDS, i);
  end

  assign s_ready = !m_valid || m_ready;
  assign accept  = s_valid && s_ready;

  // Missing or out-of-range keys pass the state through untouched and flag it.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_err   <= 1'b0;
      err_cnt <= '0;
    end else if (accept) begin
      m_valid <= 1'b1;
      m_data  <= rd_hit ? xored : s_data;
      m_err   <= !rd_hit;
      if (!rd_hit && (err_cnt != {CNT_W{1'b1}})) begin
        err_cnt <= err_cnt + 1'b1;
      end
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_add_round_key_pipe.sv
// tb/tb_add_round_key_pipe.sv - self-checking bench for add_round_key_pipe
module tb_add_round_key_pipe;

  localparam int NW = 4;
  localparam int NK = 11;
  localparam int RW = 4;
  localparam int CW = 4;
  localparam int DW = 32 * NW;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          key_wr_en = 1'b0;
  logic [RW-1:0] key_wr_idx = '0;
  logic [DW-1:0] key_wr_data = '0;
  logic          key_clr = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic [RW-1:0] s_round = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_err;
  logic [CW-1:0] err_cnt;

  int n_chk = 0;
  int n_bad = 0;

  logic [DW-1:0] mk [16];
  bit            mloaded [16];
  bit            exp_mv = 1'b0;
  logic [DW-1:0] exp_data = '0;
  bit            exp_err = 1'b0;
  int            exp_cnt = 0;

  add_round_key_pipe #(
    .NWORDS (NW),
    .NKEYS  (NK),
    .RW     (RW),
    .CNT_W  (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_wr_en   (key_wr_en),
    .key_wr_idx  (key_wr_idx),
    .key_wr_data (key_wr_data),
    .key_clr     (key_clr),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .s_round     (s_round),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_err       (m_err),
    .err_cnt     (err_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference: an output slot fed by accepted states, keys applied before updates.
  task automatic tick();
    bit rdy;
    bit hit;
    rdy = !exp_mv || m_ready;
    if (rst) begin
      exp_mv = 0; exp_data = '0; exp_err = 0; exp_cnt = 0;
      for (int k = 0; k < 16; k++) mloaded[k] = 0;
    end else begin
      if (s_valid && rdy) begin
        hit = (int'(s_round) < NK) && mloaded[s_round];
        exp_mv = 1;
        exp_data = hit ? (s_data ^ mk[s_round]) : s_data;
        exp_err = !hit;
        if (!hit && exp_cnt < CMAX) exp_cnt++;
      end else if (m_ready) begin
        exp_mv = 0;
      end
      if (key_clr) for (int k = 0; k < 16; k++) mloaded[k] = 0;
      if (key_wr_en && int'(key_wr_idx) < NK) begin
        mk[key_wr_idx] = key_wr_data;
        mloaded[key_wr_idx] = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    key_wr_en = 0; key_clr = 0; s_valid = 0; m_ready = 1; rst = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic load_key(input int idx, input logic [DW-1:0] k);
    key_wr_en = 1; key_wr_idx = RW'(idx); key_wr_data = k;
    tick();
    key_wr_en = 0;
  endtask

  task automatic send(input int r, input logic [DW-1:0] d);
    s_valid = 1; s_round = RW'(r); s_data = d; m_ready = 1;
    tick();
    s_valid = 0;
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    n_chk++;
    if (m_valid !== 1'b0 || m_err !== 1'b0 || m_data !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got v=%b e=%b d=%h need 0 0 0", m_valid, m_err, m_data);
    end
    n_chk++;
    if (err_cnt !== '0 || s_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_cnt_ready: got cnt=%0d rdy=%b need 0 1", err_cnt, s_ready);
    end
  endtask

  task automatic test_fips();
    logic [DW-1:0] want;
    want = 128'h00102030405060708090a0b0c0d0e0f0;
    load_key(0, 128'h000102030405060708090a0b0c0d0e0f);
    send(0, 128'h00112233445566778899aabbccddeeff);
    n_chk++;
    if (m_valid !== 1'b1 || m_err !== 1'b0 || m_data !== want) begin
      n_bad++;
      $display("FAIL fips_round0: got v=%b e=%b d=%h need 1 0 %h", m_valid, m_err, m_data, want);
    end
    tick();
    n_chk++;
    if (m_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL fips_drain: got m_valid=%b need 0", m_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] k;
    logic [DW-1:0] d [3];
    logic [DW-1:0] q [$];
    int sent = 0;
    int got = 0;
    k = rnd128();
    for (int i = 0; i < 3; i++) d[i] = rnd128();
    load_key(0, k);
    for (int cyc = 0; cyc < 20; cyc++) begin
      m_ready = (cyc >= 5);
      s_valid = (sent < 3);
      s_round = 0;
      s_data = d[sent < 3 ? sent : 2];
      #1;
      if (m_valid && !m_ready) begin
        n_chk++;
        if (s_ready !== 1'b0 || q.size() == 0 || m_data !== q[0]) begin
          n_bad++;
          $display("FAIL bp_hold: got rdy=%b d=%h need rdy=0 and held first result", s_ready, m_data);
        end
      end
      if (m_valid && m_ready) begin
        n_chk++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL bp_extra: got output %h need none", m_data);
        end else if (m_data !== q[0]) begin
          n_bad++;
          $display("FAIL bp_order: got %h need %h", m_data, q[0]);
        end
        if (q.size() != 0) void'(q.pop_front());
        got++;
      end
      if (s_valid && s_ready) begin
        q.push_back(d[sent] ^ k);
        sent++;
      end
      tick();
    end
    s_valid = 0;
    n_chk++;
    if (got != 3 || sent != 3) begin
      n_bad++;
      $display("FAIL bp_count: got delivered=%0d sent=%0d need 3 3", got, sent);
    end
  endtask

  task automatic test_missing_key();
    logic [DW-1:0] d;
    logic [DW-1:0] k;
    do_reset();
    d = rnd128();
    send(5, d);
    n_chk++;
    if (m_err !== 1'b1 || m_data !== d || err_cnt !== CW'(1)) begin
      n_bad++;
      $display("FAIL missing_slot5: got e=%b d=%h cnt=%0d need 1 %h 1", m_err, m_data, err_cnt, d);
    end
    d = rnd128();
    send(12, d);
    n_chk++;
    if (m_err !== 1'b1 || m_data !== d || err_cnt !== CW'(2)) begin
      n_bad++;
      $display("FAIL range_slot12: got e=%b d=%h cnt=%0d need 1 %h 2", m_err, m_data, err_cnt, d);
    end
    k = rnd128();
    load_key(10, k);
    d = rnd128();
    send(10, d);
    n_chk++;
    if (m_err !== 1'b0 || m_data !== (d ^ k) || err_cnt !== CW'(2)) begin
      n_bad++;
      $display("FAIL last_slot10: got e=%b d=%h cnt=%0d need 0 %h 2", m_err, m_data, err_cnt, d ^ k);
    end
    send(11, d);
    n_chk++;
    if (m_err !== 1'b1 || err_cnt !== CW'(3)) begin
      n_bad++;
      $display("FAIL range_slot11: got e=%b cnt=%0d need 1 3", m_err, err_cnt);
    end
  endtask

  task automatic test_collision();
    logic [DW-1:0] ka, kb, d1, d2;
    ka = rnd128(); kb = rnd128(); d1 = rnd128(); d2 = rnd128();
    load_key(1, ka);
    key_wr_en = 1; key_wr_idx = 1; key_wr_data = kb;
    send(1, d1);
    key_wr_en = 0;
    n_chk++;
    if (m_err !== 1'b0 || m_data !== (d1 ^ ka)) begin
      n_bad++;
      $display("FAIL collide_old: got e=%b d=%h need 0 %h", m_err, m_data, d1 ^ ka);
    end
    send(1, d2);
    n_chk++;
    if (m_err !== 1'b0 || m_data !== (d2 ^ kb)) begin
      n_bad++;
      $display("FAIL collide_new: got e=%b d=%h need 0 %h", m_err, m_data, d2 ^ kb);
    end
  endtask

  task automatic test_clr_wr();
    logic [DW-1:0] k, d;
    int order [4] = '{3, 0, 1, 2};
    for (int i = 0; i < 4; i++) load_key(i, rnd128());
    k = rnd128();
    key_clr = 1; key_wr_en = 1; key_wr_idx = 3; key_wr_data = k;
    tick();
    key_clr = 0; key_wr_en = 0;
    for (int i = 0; i < 4; i++) begin
      d = rnd128();
      send(order[i], d);
      n_chk++;
      if (order[i] == 3) begin
        if (m_err !== 1'b0 || m_data !== (d ^ k)) begin
          n_bad++;
          $display("FAIL clrwr_slot3: got e=%b d=%h need 0 %h", m_err, m_data, d ^ k);
        end
      end else if (m_err !== 1'b1 || m_data !== d) begin
        n_bad++;
        $display("FAIL clrwr_slot%0d: got e=%b d=%h need 1 %h", order[i], m_err, m_data, d);
      end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < CMAX + 5; i++) send(15, rnd128());
    n_chk++;
    if (err_cnt !== CW'(CMAX) || m_err !== 1'b1) begin
      n_bad++;
      $display("FAIL saturate: got cnt=%0d e=%b need %0d 1", err_cnt, m_err, CMAX);
    end
  endtask

  task automatic test_reset_mid();
    load_key(0, rnd128());
    send(7, rnd128());
    m_ready = 0;
    s_valid = 1; s_round = 0; s_data = rnd128();
    tick();
    s_valid = 0;
    n_chk++;
    if (m_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL midrst_pre: got m_valid=%b need 1", m_valid);
    end
    rst = 1;
    tick();
    rst = 0;
    n_chk++;
    if (m_valid !== 1'b0 || err_cnt !== '0 || s_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL midrst_post: got v=%b cnt=%0d rdy=%b need 0 0 1", m_valid, err_cnt, s_ready);
    end
    for (int r = 0; r < 4; r++) begin
      send(r, rnd128());
      n_chk++;
      if (m_err !== 1'b1) begin
        n_bad++;
        $display("FAIL midrst_empty%0d: got m_err=%b need 1", r, m_err);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < NK; i++) load_key(i, rnd128());
    for (int cyc = 0; cyc < 400; cyc++) begin
      s_valid = $urandom_range(0, 1);
      m_ready = ($urandom_range(0, 3) != 0);
      s_round = RW'($urandom_range(0, 15));
      s_data = rnd128();
      key_wr_en = ($urandom_range(0, 3) == 0);
      key_wr_idx = RW'($urandom_range(0, 15));
      key_wr_data = rnd128();
      key_clr = ($urandom_range(0, 29) == 0);
      #1;
      n_chk++;
      if (s_ready !== (!exp_mv || m_ready)) begin
        n_bad++;
        $display("FAIL rnd_ready c%0d: got %b need %b", cyc, s_ready, !exp_mv || m_ready);
      end
      tick();
      n_chk++;
      if (m_valid !== exp_mv || err_cnt !== CW'(exp_cnt) ||
          (exp_mv && (m_data !== exp_data || m_err !== exp_err))) begin
        n_bad++;
        $display("FAIL rnd_out c%0d: got v=%b e=%b d=%h cnt=%0d need v=%b e=%b d=%h cnt=%0d",
                 cyc, m_valid, m_err, m_data, err_cnt, exp_mv, exp_err, exp_data, exp_cnt);
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_fips();
    test_backpressure();
    test_missing_key();
    test_collision();
    test_clr_wr();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
